// File: rtl/shift_iter_unit_if.sv
// Request/response bundle for shift_iter_unit.
// The master drives the request fields and the slave returns busy, done and dout.
interface shift_iter_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TOT_W  = 5
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic [TOT_W-1:0]  tot_amt;
  logic              dir;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] dout;

  modport master (
    output start, din, tot_amt, dir, mode,
    input  busy, done, dout
  );

  modport slave (
    input  start, din, tot_amt, dir, mode,
    output busy, done, dout
  );
endinterface

// File: rtl/shift_iter_unit.sv
// Multi-cycle shift engine.
// A total shift amount is split into passes of at most 2^STEP_W-1 positions,
// with one barrel-style pass applied per clock. The result is presented on
// dout together with a one-cycle done strobe.
// Optional macro SHIFT_ARITH_EN enables arithmetic right shift for mode 2'b10.
// Without the macro, mode 2'b10 behaves as a logical shift.
module shift_iter_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STEP_W = 3,
  parameter int unsigned TOT_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  shift_iter_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [TOT_W-1:0] MAX_STEP = TOT_W'((1 << STEP_W) - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] word, word_next;
  logic [TOT_W-1:0]  remaining, rem_next;
  logic [STEP_W-1:0] step;
  logic              dir_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] dout_q;

  // Apply a single pass of s positions to w.
  function automatic logic [DATA_W-1:0] pass_fn(
    input logic [DATA_W-1:0] w,
    input logic [STEP_W-1:0] s,
    input logic              d,
    input logic [1:0]        m
  );
    logic [2*DATA_W-1:0] dbl;
    logic [DATA_W-1:0]   r;
    if (m == 2'b00) begin
      // Rotate is done on a doubled word so bits shifted out wrap back in.
      dbl = d ? ({w, w} >> s) : ({w, w} << s);
      r   = d ? dbl[DATA_W-1:0] : dbl[2*DATA_W-1:DATA_W];
    end else begin
      r = d ? (w >> s) : (w << s);
    end
`ifdef SHIFT_ARITH_EN
    // The sign bit stays in place on each pass, so every pass fills with the
    // captured MSB.
    if (m == 2'b10 && d) begin
      r = $unsigned($signed(w) >>> s);
    end
`endif
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Compute the next state, the step size and the next word/remaining values.
  always_comb begin
    state_next = state;
    word_next  = word;
    rem_next   = remaining;
    step       = (remaining > MAX_STEP) ? MAX_STEP[STEP_W-1:0] : remaining[STEP_W-1:0];
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          word_next  = bus.din;
          rem_next   = bus.tot_amt;
          state_next = (bus.tot_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        word_next = pass_fn(word, step, dir_q, mode_q);
        rem_next  = remaining - TOT_W'(step);
        if (remaining <= MAX_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers: working word, remaining count, frozen controls and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      word      <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      mode_q    <= '0;
      dout_q    <= '0;
    end else begin
      word      <= word_next;
      remaining <= rem_next;
      if (state == IDLE && bus.start) begin
        dir_q  <= bus.dir;
        mode_q <= bus.mode;
      end
      // Load the result from the word being written on the same edge, so that
      // dout already holds the final value during the DONE cycle.
      if (state_next == DONE && state != DONE) begin
        dout_q <= word_next;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_shift_iter_unit.sv
// Directed testbench for shift_iter_unit.
module tb_shift_iter_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  shift_iter_unit_if #(.DATA_W(8), .TOT_W(5)) bus();

  shift_iter_unit #(.DATA_W(8), .STEP_W(3), .TOT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request. The task returns the number of edges after the start
  // edge until done is seen (-1 on timeout), the dout value while done is
  // high, and the number of sampled cycles with busy high.
  task automatic do_op(input logic [7:0] d, input logic [4:0] amt, input logic dr,
                       input logic [1:0] md, output int lat, output logic [7:0] res,
                       output int busy_cnt);
    int n;
    @(posedge clk); #1;
    bus.din = d; bus.tot_amt = amt; bus.dir = dr; bus.mode = md; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1; res = 'x; busy_cnt = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = n; res = bus.dout;
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.din = '0; bus.tot_amt = '0; bus.dir = 1'b0; bus.mode = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.dout} !== 10'b0)
      $display("FAIL reset_state: got busy=%b done=%b dout=%h, want 0 0 00", bus.busy, bus.done, bus.dout);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_rotate();
    int lat, bc; logic [7:0] res;
    do_op(8'b11010111, 5'd1, 1'b1, 2'b00, lat, res, bc);
    checks++; if (lat !== 1) $display("FAIL ror1_latency: got %0d want 1", lat); else passes++;
    checks++; if (res !== 8'b11101011) $display("FAIL ror1_dout: got %b want 11101011", res); else passes++;
    checks++; if (bc !== 2) $display("FAIL ror1_busy_cycles: got %0d want 2", bc); else passes++;
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", bus.done); else passes++;
    checks++; if (bus.dout !== 8'b11101011) $display("FAIL dout_hold: got %b want 11101011", bus.dout); else passes++;

    // Rotate left by 10; inputs are scrambled during SHIFT to confirm they are frozen.
    @(posedge clk); #1;
    bus.din = 8'b11010111; bus.tot_amt = 5'd10; bus.dir = 1'b0; bus.mode = 2'b00; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.din = 8'h00; bus.dir = 1'b1; bus.mode = 2'b01; bus.tot_amt = 5'd3;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.done) begin lat = n; res = bus.dout; break; end
    end
    checks++; if (lat !== 2) $display("FAIL rol10_latency: got %0d want 2", lat); else passes++;
    checks++; if (res !== 8'b01011111) $display("FAIL rol10_dout: got %b want 01011111", res); else passes++;
  endtask

  task automatic test_logical();
    int lat, bc; logic [7:0] res;
    do_op(8'b00000001, 5'd9, 1'b0, 2'b01, lat, res, bc);
    checks++; if (lat !== 2) $display("FAIL lsl9_latency: got %0d want 2", lat); else passes++;
    checks++; if (res !== 8'h00) $display("FAIL lsl9_dout: got %h want 00", res); else passes++;
    do_op(8'b11110011, 5'd3, 1'b1, 2'b01, lat, res, bc);
    checks++; if (res !== 8'b00011110) $display("FAIL lsr3_dout: got %b want 00011110", res); else passes++;
    do_op(8'hFF, 5'd8, 1'b1, 2'b01, lat, res, bc);
    checks++; if (lat !== 2) $display("FAIL lsr8_latency: got %0d want 2", lat); else passes++;
    checks++; if (res !== 8'h00) $display("FAIL lsr8_dout: got %h want 00", res); else passes++;
    do_op(8'b11110011, 5'd3, 1'b1, 2'b11, lat, res, bc);
    checks++; if (res !== 8'b00011110) $display("FAIL mode11_dout: got %b want 00011110", res); else passes++;
    do_op(8'b11110011, 5'd3, 1'b0, 2'b10, lat, res, bc);
    checks++; if (res !== 8'b10011000) $display("FAIL asl3_dout: got %b want 10011000", res); else passes++;
  endtask

  task automatic test_zero_and_ignore();
    int lat, bc, extra; logic [7:0] res;
    do_op(8'hA5, 5'd0, 1'b0, 2'b00, lat, res, bc);
    checks++; if (lat !== 0) $display("FAIL zero_latency: got %0d want 0", lat); else passes++;
    checks++; if (res !== 8'hA5) $display("FAIL zero_dout: got %h want A5", res); else passes++;
    checks++; if (bc !== 1) $display("FAIL zero_busy_cycles: got %0d want 1", bc); else passes++;

    // Long rotate; start pulses in SHIFT and in DONE must be ignored.
    @(posedge clk); #1;
    bus.din = 8'h80; bus.tot_amt = 5'd31; bus.dir = 1'b1; bus.mode = 2'b00; bus.start = 1'b1;
    @(posedge clk); #1;          // edge k
    bus.start = 1'b0;
    @(posedge clk); #1;          // edge k+1, SHIFT
    bus.din = 8'h3C; bus.tot_amt = 5'd0; bus.start = 1'b1;
    @(posedge clk); #1;          // edge k+2
    bus.start = 1'b0;
    lat = -1;
    for (int n = 2; n < 30; n++) begin
      @(negedge clk);
      if (bus.done) begin lat = n; res = bus.dout; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat !== 5) $display("FAIL ror31_latency: got %0d want 5", lat); else passes++;
    checks++; if (res !== 8'h01) $display("FAIL ror31_dout: got %h want 01", res); else passes++;
    #1 bus.start = 1'b1;         // asserted during the DONE cycle
    @(posedge clk); #1;
    bus.start = 1'b0;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checks++; if (extra !== 0) $display("FAIL ignored_start_done: got %0d extra done, want 0", extra); else passes++;
    checks++; if (bus.dout !== 8'h01) $display("FAIL ignored_start_dout: got %h want 01", bus.dout); else passes++;
  endtask

  task automatic test_reset_abort();
    int extra;
    @(posedge clk); #1;
    bus.din = 8'h80; bus.tot_amt = 5'd31; bus.dir = 1'b1; bus.mode = 2'b00; bus.start = 1'b1;
    @(posedge clk); #1;          // edge k
    bus.start = 1'b0;
    @(posedge clk); #1;          // edge k+1
    @(posedge clk); #1;          // edge k+2: third pass cycle
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", bus.busy); else passes++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.dout} !== 10'b0)
      $display("FAIL abort_state: got busy=%b done=%b dout=%h, want 0 0 00", bus.busy, bus.done, bus.dout);
    else passes++;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checks++; if (extra !== 0) $display("FAIL abort_no_done: got %0d done pulses, want 0", extra); else passes++;
  endtask

  task automatic test_arith();
    int lat, bc; logic [7:0] res, exp;
`ifdef SHIFT_ARITH_EN
    exp = 8'b11111110;
`else
    exp = 8'b00011110;
`endif
    do_op(8'b11110011, 5'd3, 1'b1, 2'b10, lat, res, bc);
    checks++; if (res !== exp) $display("FAIL asr3_dout: got %b want %b", res, exp); else passes++;
`ifdef SHIFT_ARITH_EN
    exp = 8'hFF;
`else
    exp = 8'h00;
`endif
    do_op(8'h81, 5'd12, 1'b1, 2'b10, lat, res, bc);
    checks++; if (res !== exp) $display("FAIL asr12_dout: got %h want %h", res, exp); else passes++;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_logical();
    test_zero_and_ignore();
    test_reset_abort();
    test_arith();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/shift_iter_unit.md
Name: shift_iter_unit

Overview:
- Multi-cycle shift engine placed directly upstream of the 8-bit barrel-shifter datapath users; accepts a word plus a total shift amount larger than one shifter pass can handle (0..31).
- Decomposes the amount into per-pass steps of at most 7 positions, applies one barrel-style pass per clock to an internal register, and reports the result with a done pulse.
- Supports rotate and logical shift, left or right.

Parameters:
- DATA_W, 8, operand/result width
- STEP_W, 3, per-pass amount width; max step = 2^STEP_W-1 = 7
- TOT_W, 5, total shift-amount width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- din  input  DATA_W  operand
- tot_amt  input  TOT_W  total shift amount
- dir  input  1  0 = left, 1 = right
- mode  input  2  00 rotate, 01 logical, 10 arithmetic (see Optional Feature), 11 treated as logical
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle completion strobe
- dout  output  DATA_W  result; holds until next completion

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, dout=0, internal word/remaining=0.
- FSM, Moore outputs:
  - IDLE: on start=1 at edge k, capture din, tot_amt, dir and mode into internal registers. Go to DONE if tot_amt=0, else go to SHIFT.
  - SHIFT: each edge, step=min(remaining,7); word<=pass(word,step); remaining<=remaining-step. Go to DONE when remaining-step=0.
  - DONE: done=1 for exactly this one cycle; dout<=word on entry, so dout is valid while done=1. Next edge returns to IDLE.
- Latency: N=ceil(tot_amt/7) pass cycles. done is high in the cycle following edge k+N. The zero-amount case gives N=0, so done follows edge k with dout=din.
- Pass function, DATA_W=8:
  - Rotate: circular, per pass.
  - Logical: zero fill. Totals of 8 or more yield 0.
  - Left arithmetic is identical to left logical.
- dir and mode are frozen at capture; input changes during SHIFT have no effect.
- start while busy is ignored and is not queued.
- start asserted in the DONE cycle is ignored. A new request is accepted no earlier than the following IDLE cycle.
- reset mid-operation aborts immediately: IDLE, done=0, dout=0 on the next edge, and no done pulse is produced.
- tot_amt=31: five passes (7,7,7,7,3).

Optional Feature:
- Macro SHIFT_ARITH_EN.
- Defined: mode=10 with dir=1 performs arithmetic right shift, filling with the captured MSB on every pass. Totals of 8 or more yield all copies of the sign bit.
- Undefined: mode=10 behaves exactly as logical (01), and no sign-fill logic is synthesized.

Test Plan:
- din=8'b11010111, tot_amt=1, dir=1, mode=00, start at edge k -> done in the cycle after edge k+1, dout=8'b11101011, busy high for 2 cycles.
- din=8'b11010111, tot_amt=10, dir=0, mode=00 -> passes of 7 then 3, done after edge k+2, dout=8'b01011111.
- din=8'b00000001, tot_amt=9, dir=0, mode=01 -> dout=8'h00 after 2 passes. Then din=8'b11110011, tot_amt=3, dir=1, mode=01 -> dout=8'b00011110.
- tot_amt=0, din=8'hA5 -> done in the cycle after the start edge, dout=8'hA5. A start pulse asserted during SHIFT/DONE is ignored: no second done, dout unchanged.
- tot_amt=31, din=8'h80, dir=1, mode=00 -> five passes, dout=8'h01 (rotate by 31 mod 8=7 right). Assert reset during the third pass -> next cycle busy=0, done=0, dout=8'h00, and no done pulse afterwards.
- din=8'b11110011, tot_amt=3, dir=1, mode=10 -> with SHIFT_ARITH_EN dout=8'b11111110; without it dout=8'b00011110.
